// File: rtl/four_rr_sel_arb.sv
// Four-channel round-robin arbiter driving the select of a downstream 4:1 mux, with burst hold.
// Optional per-channel exclusion mask is enabled by defining CH_MASK_EN.
module four_rr_sel_arb #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
`ifdef CH_MASK_EN
  input  logic [3:0] ch_mask,
`endif
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  // Returns {found, index} of the first set bit of elig, scanning upward from start with wrap.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (elig[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  logic [3:0] eligible_s;
  logic [1:0] pick_start_s;
  logic [2:0] pick_s;
  logic       busy_s;
  logic       out_valid_s;
  logic       transfer_s;
  logic       release_s;

`ifdef CH_MASK_EN
  assign eligible_s = req & ~ch_mask;
`else
  assign eligible_s = req;
`endif

  // While busy the search begins just past the current owner, so it is considered last.
  assign pick_start_s = (state_q == ST_BUSY) ? (sel_q + 2'd1) : ptr_q;
  assign pick_s       = rr_pick(eligible_s, pick_start_s);

  assign busy_s      = (state_q == ST_BUSY);
  assign out_valid_s = busy_s & eligible_s[sel_q];
  assign transfer_s  = out_valid_s & out_ready;
  assign release_s   = (transfer_s & (beat_cnt_q == LAST_BEAT)) | ~eligible_s[sel_q];

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign busy      = busy_s;
  assign out_valid = out_valid_s;
  assign ack       = transfer_s ? onehot4(sel_q) : 4'b0000;

  // Next-state logic: grant from idle, count beats, and rotate on burst end or request drop.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_d    = ST_BUSY;
          sel_d      = pick_s[1:0];
          grant_d    = onehot4(pick_s[1:0]);
          beat_cnt_d = 8'd0;
        end else begin
          grant_d = 4'b0000;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          ptr_d      = sel_q + 2'd1;
          beat_cnt_d = 8'd0;
          if (pick_s[2]) begin
            state_d = ST_BUSY;
            sel_d   = pick_s[1:0];
            grant_d = onehot4(pick_s[1:0]);
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
          end
        end else if (transfer_s) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = 4'b0000;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'b00;
      grant_q    <= 4'b0000;
      ptr_q      <= 2'b00;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_four_rr_sel_arb.sv
// Directed bench for four_rr_sel_arb: main instance with BURST_LEN=4, second with BURST_LEN=1.
module tb_four_rr_sel_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] ch_mask;
  logic [1:0] sel, sel1;
  logic [3:0] grant, grant1;
  logic       out_valid, out_valid1;
  logic [3:0] ack, ack1;
  logic       busy, busy1;

  int n_tests;
  int n_fail;

  four_rr_sel_arb #(.BURST_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
`ifdef CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .sel(sel), .grant(grant), .out_valid(out_valid), .ack(ack), .busy(busy)
  );

  four_rr_sel_arb #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
`ifdef CH_MASK_EN
    .ch_mask(ch_mask),
`endif
    .sel(sel1), .grant(grant1), .out_valid(out_valid1), .ack(ack1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    ch_mask = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({sel, grant, out_valid, ack, busy} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got sel=%b grant=%b ov=%b ack=%b busy=%b want all 0",
                 c, sel, grant, out_valid, ack, busy);
      end
    end
  endtask

  task automatic test_single_requester();
    apply_reset();
    req = 4'b0001;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if ({grant, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_idle: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if ({sel, grant, ack} !== 10'b00_0001_0001) begin
        n_fail++;
        $display("FAIL single_burst cyc%0d: got sel=%b grant=%b ack=%b want 00/0001/0001",
                 c, sel, grant, ack);
      end
      tick();
    end
    req = 4'b0000;
    #1;
    n_tests++;
    if ({out_valid, ack} !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_drop: got ov=%b ack=%b want 0/0000", out_valid, ack);
    end
    tick();
    n_tests++;
    if ({sel, grant, busy} !== 7'b00_0000_0) begin
      n_fail++;
      $display("FAIL single_idle_after: got sel=%b grant=%b busy=%b want 00/0000/0", sel, grant, busy);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel;
    logic [3:0] exp_oh;
    logic [1:0] exp_sel1;
    logic [3:0] exp_oh1;
    apply_reset();
    req = 4'b1111;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      exp_sel  = 2'((k / 4) % 4);
      exp_oh   = 4'b0001 << exp_sel;
      exp_sel1 = 2'(k % 4);
      exp_oh1  = 4'b0001 << exp_sel1;
      #1;
      n_tests++;
      if ({sel, grant, ack} !== {exp_sel, exp_oh, exp_oh}) begin
        n_fail++;
        $display("FAIL rotation_b4 cyc%0d: got sel=%b grant=%b ack=%b want %b/%b/%b",
                 k, sel, grant, ack, exp_sel, exp_oh, exp_oh);
      end
      n_tests++;
      if ({sel1, grant1, ack1} !== {exp_sel1, exp_oh1, exp_oh1}) begin
        n_fail++;
        $display("FAIL rotation_b1 cyc%0d: got sel=%b grant=%b ack=%b want %b/%b/%b",
                 k, sel1, grant1, ack1, exp_sel1, exp_oh1, exp_oh1);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req = 4'b0010;
    out_ready = 1'b1;
    tick();
    req = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if ({grant, ack} !== 8'b0010_0010) begin
        n_fail++;
        $display("FAIL bp_first_beats cyc%0d: got grant=%b ack=%b want 0010/0010", c, grant, ack);
      end
      tick();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if ({sel, grant, out_valid, ack} !== 11'b01_0010_1_0000) begin
        n_fail++;
        $display("FAIL bp_stall cyc%0d: got sel=%b grant=%b ov=%b ack=%b want 01/0010/1/0000",
                 c, sel, grant, out_valid, ack);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if ({grant, ack} !== 8'b0010_0010) begin
        n_fail++;
        $display("FAIL bp_last_beats cyc%0d: got grant=%b ack=%b want 0010/0010", c, grant, ack);
      end
      tick();
    end
    #1;
    n_tests++;
    if ({sel, grant} !== 6'b00_0001) begin
      n_fail++;
      $display("FAIL bp_rotate: got sel=%b grant=%b want 00/0001", sel, grant);
    end
  endtask

  task automatic test_drop_release();
    apply_reset();
    req = 4'b0100;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: got busy=%b want 0", busy);
    end
    tick();
    n_tests++;
    if ({grant, ack} !== 8'b0100_0100) begin
      n_fail++;
      $display("FAIL drop_ch2: got grant=%b ack=%b want 0100/0100", grant, ack);
    end
    tick();
    req = 4'b1000;
    #1;
    n_tests++;
    if ({out_valid, ack} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL drop_cycle: got ov=%b ack=%b want 0/0000", out_valid, ack);
    end
    tick();
    n_tests++;
    if ({sel, grant, ack} !== 10'b11_1000_1000) begin
      n_fail++;
      $display("FAIL drop_ch3: got sel=%b grant=%b ack=%b want 11/1000/1000", sel, grant, ack);
    end
    tick();
    req = 4'b0000;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_none: got ov=%b want 0", out_valid);
    end
    tick();
    n_tests++;
    if ({sel, grant, busy} !== 7'b11_0000_0) begin
      n_fail++;
      $display("FAIL drop_to_idle: got sel=%b grant=%b busy=%b want 11/0000/0", sel, grant, busy);
    end
    req = 4'b1111;
    tick();
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_ptr_wrap: got grant=%b want 0001", grant);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] exp_first;
    apply_reset();
    req = 4'b1000;
    out_ready = 1'b1;
    tick();
    #1;
    n_tests++;
    if ({grant, ack} !== 8'b1000_1000) begin
      n_fail++;
      $display("FAIL rstmid_pre: got grant=%b ack=%b want 1000/1000", grant, ack);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({grant, out_valid, ack, busy} !== 10'b0000_0_0000_0) begin
      n_fail++;
      $display("FAIL rstmid_async: got grant=%b ov=%b ack=%b busy=%b want 0000/0/0000/0",
               grant, out_valid, ack, busy);
    end
    req = 4'b1010;
`ifdef CH_MASK_EN
    ch_mask = 4'b0010;
    exp_first = 4'b1000;
`else
    exp_first = 4'b0010;
`endif
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({grant, busy} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL rstmid_release: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    n_tests++;
    if (grant !== exp_first) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: got grant=%b want %b", grant, exp_first);
    end
    ch_mask = 4'b0000;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req = 4'b0000;
    out_ready = 1'b0;
    ch_mask = 4'b0000;
    test_reset();
    test_single_requester();
    test_rotation();
    test_backpressure();
    test_drop_release();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
